// File: rtl/async_fifo.sv
// -----------------------------------------------------------------------------
// async_fifo
// Single-clock first-word-fall-through FIFO between a producer and a consumer.
// Depth is 2**ADDR_WIDTH words. Full and empty come from (ADDR_WIDTH+1)-bit
// pointers whose MSB is a wrap bit. Both flags are combinational from the
// registered pointers, so they update on the same edge as the pointers.
//
// Parameters
//   DATA_WIDTH : width of each stored word (default 16)
//   ADDR_WIDTH : log2 of depth, legal range 2..12 (default 4 -> depth 16)
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset; clears the pointers and flags
//   wr_data  in   word to enqueue
//   wr_en    in   write request; dropped while full
//   full     out  1 = no free slot
//   rd_data  out  head-of-queue word; 0 while empty
//   rd_en    in   pop request; ignored while empty
//   empty    out  1 = no stored word
//   level    out  occupancy 0..2**ADDR_WIDTH (only with ASYNC_FIFO_LEVEL_EN)
//
// Configuration
//   `define ASYNC_FIFO_LEVEL_EN adds the level output port and its logic.
// -----------------------------------------------------------------------------
module async_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_en,
  output logic                  empty
`ifdef ASYNC_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level
`endif
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  wr_fire;
  logic                  rd_fire;

  // Flags and accept decisions. Same low bits with the same wrap bit means
  // empty. Same low bits with different wrap bits means the writer is a full
  // lap ahead.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    empty    = 1'b0;
    full     = 1'b0;
    wr_fire  = 1'b0;
    rd_fire  = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
            (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

    // Each side is gated only by its own flag. A simultaneous read at full
    // or write at empty therefore takes effect one cycle later, once the
    // flag clears.
    wr_fire = wr_en && !full;
    rd_fire = rd_en && !empty;

    // The pointers roll over naturally at 2**(ADDR_WIDTH+1).
    if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples its pre-edge value regardless of statement order.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage
  // NOTE: the memory is deliberately left out of the reset. Clearing the
  // pointers already discards the contents, and leaving the array unreset
  // lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  // First-word-fall-through read port. The output is forced to zero while
  // empty, so stale words never leak out after a drain or a reset.
  always_comb begin
    rd_data = '0;
    if (!empty) begin
      rd_data = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
  end

`ifdef ASYNC_FIFO_LEVEL_EN
  // Modular difference of the wrap-bit pointers gives the occupancy
  // 0..DEPTH directly. It changes on the same edges as the pointers.
  assign level = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// -----------------------------------------------------------------------------
// tb_async_fifo
// Directed and randomized bench for async_fifo (DATA_WIDTH=16, ADDR_WIDTH=4).
// The reference model is a plain queue of stored words. Each cycle the model
// accepts a write if it holds fewer than DEPTH words, and accepts a pop if it
// holds at least one word; both decisions use the pre-edge occupancy.
// Expected flags, head word and level are derived from the queue.
// -----------------------------------------------------------------------------
module tb_async_fifo;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          full;
  logic [DW-1:0] rd_data;
  logic          rd_en;
  logic          empty;
`ifdef ASYNC_FIFO_LEVEL_EN
  logic [AW:0]   level;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] model_q[$];  // reference contents, head at index 0
  logic [DW-1:0] popped[$];   // words the DUT presented when a pop was accepted

  async_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .rd_data (rd_data),
    .rd_en   (rd_en),
    .empty   (empty)
`ifdef ASYNC_FIFO_LEVEL_EN
    ,
    .level   (level)
`endif
  );

  always #5 clk = ~clk;

  // Watchdog: the run must always terminate on its own.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the state of the model.
  task automatic check_outputs(input string tag);
    logic [DW-1:0] head;
    head = (model_q.size() != 0) ? model_q[0] : '0;
    check({tag, ".empty"},   32'(empty),   32'(model_q.size() == 0));
    check({tag, ".full"},    32'(full),    32'(model_q.size() == DEPTH));
    check({tag, ".rd_data"}, 32'(rd_data), 32'(head));
`ifdef ASYNC_FIFO_LEVEL_EN
    check({tag, ".level"},   32'(level),   32'(model_q.size()));
`endif
  endtask

  // One clock cycle: drive inputs, apply the edge to the model, and check
  // the outputs 1 time unit after the edge.
  task automatic cycle(input string tag, input logic we, input logic [DW-1:0] wd,
                       input logic re);
    logic wacc;
    logic racc;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    wacc = we && (model_q.size() < DEPTH);
    racc = re && (model_q.size() != 0);
    if (re && !empty) popped.push_back(rd_data);
    @(posedge clk);
    if (racc) void'(model_q.pop_front());
    if (wacc) model_q.push_back(wd);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int next_wr;
    int n;
    logic we;
    logic re;

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill with 0..15 and no reads, then attempt a 17th write that must be dropped.
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, DW'(i), 1'b0);
    check("fill.full_after_16", 32'(full), 32'd1);
    cycle("fill_overflow", 1'b1, 16'd99, 1'b0);
    check("fill.head_after_drop", 32'(rd_data), 32'd0);

    // Drain 16 words in order, then issue one extra pop.
    popped.delete();
    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, '0, 1'b1);
    check("drain.count", 32'(popped.size()), 32'(DEPTH));
    for (int i = 0; i < popped.size(); i++) check("drain.order", 32'(popped[i]), 32'(i));
    check("drain.empty_after_16", 32'(empty), 32'd1);
    cycle("drain_extra", 1'b0, '0, 1'b1);
    check("drain_extra.rd_data", 32'(rd_data), 32'd0);

    // Simultaneous read and write while full: only the pop is accepted.
    for (int i = 0; i < DEPTH; i++) cycle("refill", 1'b1, DW'(100 + i), 1'b0);
    popped.delete();
    cycle("simul_full", 1'b1, 16'hAAAA, 1'b1);
    check("simul_full.full_cleared", 32'(full), 32'd0);
    check("simul_full.popped_head", 32'(popped[0]), 32'd100);
    check("simul_full.new_head", 32'(rd_data), 32'd101);
    for (int i = 0; i < DEPTH - 1; i++) cycle("simul_full_drain", 1'b0, '0, 1'b1);

    // Simultaneous read and write while empty: only the write is accepted.
    cycle("simul_empty", 1'b1, 16'h0055, 1'b1);
    check("simul_empty.rd_data", 32'(rd_data), 32'h55);
    check("simul_empty.empty", 32'(empty), 32'd0);
    cycle("simul_empty_pop", 1'b0, '0, 1'b1);

    // Streaming 0..49: write whenever there is room, read on roughly 2 of 3
    // cycles. Several pointer wraps happen along the way.
    popped.delete();
    next_wr = 0;
    n = 0;
    while (popped.size() < 50 && n < 600) begin
      we = (next_wr < 50) && (model_q.size() < DEPTH);
      re = ($urandom_range(2) != 0);
      cycle("stream", we, DW'(next_wr), re);
      if (we) next_wr++;
      n++;
    end
    check("stream.count", 32'(popped.size()), 32'd50);
    for (int i = 0; i < popped.size(); i++) check("stream.order", 32'(popped[i]), 32'(i));

    // Randomized traffic, including writes while full and reads while empty.
    for (int i = 0; i < 400; i++) begin
      cycle("random", 1'($urandom_range(1)), DW'($urandom), 1'($urandom_range(1)));
    end

    // Drain what remains, store five words, then assert reset between edges.
    while (model_q.size() != 0) cycle("pre_reset_drain", 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) cycle("pre_reset_fill", 1'b1, DW'(16'h200 + i), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_q.delete();
    check("midreset.empty", 32'(empty), 32'd1);
    check("midreset.full", 32'(full), 32'd0);
    check("midreset.rd_data", 32'(rd_data), 32'd0);
`ifdef ASYNC_FIFO_LEVEL_EN
    check("midreset.level", 32'(level), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    cycle("post_reset_write", 1'b1, 16'd7, 1'b0);
    check("post_reset.rd_data", 32'(rd_data), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
